// File: rtl/ux607_tl_qspi_byte_responder.sv
// Byte-wide TileLink-UL responder behind the QSPI fragmenter.
// Each single-byte A beat becomes at most one byte-engine transaction and
// always exactly one in-order D beat. One transaction in flight at a time;
// an 8-bit response timer keeps a hung engine from stalling the bus.
module ux607_tl_qspi_byte_responder #(
  parameter int ADDR_W  = 30,
  parameter int SRC_W   = 7,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  output logic              io_in_a_ready,
  input  logic              io_in_a_valid,
  input  logic [2:0]        io_in_a_bits_opcode,
  input  logic [2:0]        io_in_a_bits_param,
  input  logic [2:0]        io_in_a_bits_size,
  input  logic [SRC_W-1:0]  io_in_a_bits_source,
  input  logic [ADDR_W-1:0] io_in_a_bits_address,
  input  logic              io_in_a_bits_mask,
  input  logic [7:0]        io_in_a_bits_data,
  input  logic              io_in_d_ready,
  output logic              io_in_d_valid,
  output logic [2:0]        io_in_d_bits_opcode,
  output logic [1:0]        io_in_d_bits_param,
  output logic [2:0]        io_in_d_bits_size,
  output logic [SRC_W-1:0]  io_in_d_bits_source,
  output logic              io_in_d_bits_sink,
  output logic              io_in_d_bits_addr_lo,
  output logic [7:0]        io_in_d_bits_data,
  output logic              io_in_d_bits_error,
  output logic              io_eng_req_valid,
  input  logic              io_eng_req_ready,
  output logic              io_eng_req_write,
  output logic [ADDR_W-1:0] io_eng_req_addr,
  output logic [7:0]        io_eng_req_data,
  input  logic              io_eng_resp_valid,
  input  logic [7:0]        io_eng_resp_data,
  input  logic              io_eng_resp_error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Last timer value still spent waiting; reaching it ends the wait.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              is_get_q, is_get_d;
  logic              is_put_q, is_put_d;
  logic [2:0]        size_q, size_d;
  logic [SRC_W-1:0]  source_q, source_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        timer_q, timer_d;

  // D channel registers: loaded only when entering RESP so they hold
  // their previous contents while no response is being offered.
  logic              dget_q, dget_d;
  logic [2:0]        dsize_q, dsize_d;
  logic [SRC_W-1:0]  dsrc_q, dsrc_d;
  logic              dlo_q, dlo_d;
  logic [7:0]        ddata_q, ddata_d;
  logic              derr_q, derr_d;

  logic a_fire;
  logic a_is_get;
  logic a_is_put;
  logic a_legal;
  logic unused_param;

  assign unused_param = ^io_in_a_bits_param;

  assign a_is_get = (io_in_a_bits_opcode == 3'd4);
  assign a_is_put = (io_in_a_bits_opcode == 3'd0) || (io_in_a_bits_opcode == 3'd1);
  assign a_legal  = (a_is_get || a_is_put) && (io_in_a_bits_size == 3'd0);

  // a_ready is masked by reset so nothing is accepted while reset is held.
  assign io_in_a_ready = (state_q == S_IDLE) && reset;
  assign a_fire        = io_in_a_valid && io_in_a_ready;

  assign io_eng_req_valid = (state_q == S_REQ);
  assign io_eng_req_write = is_put_q;
  assign io_eng_req_addr  = addr_q;
  assign io_eng_req_data  = wdata_q;

  assign io_in_d_valid        = (state_q == S_RESP);
  assign io_in_d_bits_opcode  = {2'b00, dget_q};
  assign io_in_d_bits_param   = 2'b00;
  assign io_in_d_bits_size    = dsize_q;
  assign io_in_d_bits_source  = dsrc_q;
  assign io_in_d_bits_sink    = 1'b0;
  assign io_in_d_bits_addr_lo = dlo_q;
  assign io_in_d_bits_data    = ddata_q;
  assign io_in_d_bits_error   = derr_q;

  // Next-state logic: capture, classify, engine handshake, timeout, D handshake.
  always_comb begin
    state_d  = state_q;
    is_get_d = is_get_q;
    is_put_d = is_put_q;
    size_d   = size_q;
    source_d = source_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    timer_d  = timer_q;
    dget_d   = dget_q;
    dsize_d  = dsize_q;
    dsrc_d   = dsrc_q;
    dlo_d    = dlo_q;
    ddata_d  = ddata_q;
    derr_d   = derr_q;
    case (state_q)
      S_IDLE: begin
        if (a_fire) begin
          is_get_d = a_is_get;
          is_put_d = a_is_put;
          size_d   = io_in_a_bits_size;
          source_d = io_in_a_bits_source;
          addr_d   = io_in_a_bits_address;
          wdata_d  = io_in_a_bits_data;
          if (!a_legal || (a_is_put && !io_in_a_bits_mask)) begin
            // Answered locally without touching the engine.
            state_d = S_RESP;
            dget_d  = a_is_get;
            dsize_d = io_in_a_bits_size;
            dsrc_d  = io_in_a_bits_source;
            dlo_d   = io_in_a_bits_address[0];
            ddata_d = 8'h00;
            derr_d  = !a_legal;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (io_eng_req_ready) begin
          state_d = S_WAIT;
          timer_d = 8'h00;
        end
      end
      S_WAIT: begin
        if (io_eng_resp_valid || (timer_q == TIMER_LAST)) begin
          state_d = S_RESP;
          dget_d  = is_get_q;
          dsize_d = size_q;
          dsrc_d  = source_q;
          dlo_d   = addr_q[0];
          // A response arriving on the timeout cycle takes priority.
          if (io_eng_resp_valid) begin
            ddata_d = is_get_q ? io_eng_resp_data : 8'h00;
            derr_d  = io_eng_resp_error;
          end else begin
            ddata_d = 8'h00;
            derr_d  = 1'b1;
          end
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_RESP: begin
        if (io_in_d_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and payload registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      is_get_q <= 1'b0;
      is_put_q <= 1'b0;
      size_q   <= 3'd0;
      source_q <= '0;
      addr_q   <= '0;
      wdata_q  <= 8'h00;
      timer_q  <= 8'h00;
      dget_q   <= 1'b0;
      dsize_q  <= 3'd0;
      dsrc_q   <= '0;
      dlo_q    <= 1'b0;
      ddata_q  <= 8'h00;
      derr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_get_q <= is_get_d;
      is_put_q <= is_put_d;
      size_q   <= size_d;
      source_q <= source_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      timer_q  <= timer_d;
      dget_q   <= dget_d;
      dsize_q  <= dsize_d;
      dsrc_q   <= dsrc_d;
      dlo_q    <= dlo_d;
      ddata_q  <= ddata_d;
      derr_q   <= derr_d;
    end
  end

endmodule

// File: tb/tb_ux607_tl_qspi_byte_responder.sv
// Directed bench for ux607_tl_qspi_byte_responder with a transaction-level
// expectation model (queues of expected engine requests and D beats).
module tb_ux607_tl_qspi_byte_responder;
  localparam int AW = 30;
  localparam int SW = 7;
  localparam int TO = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          a_ready, a_valid;
  logic [2:0]    a_opcode, a_param, a_size;
  logic [SW-1:0] a_source;
  logic [AW-1:0] a_address;
  logic          a_mask;
  logic [7:0]    a_data;
  logic          d_ready, d_valid;
  logic [2:0]    d_opcode;
  logic [1:0]    d_param;
  logic [2:0]    d_size;
  logic [SW-1:0] d_source;
  logic          d_sink, d_addr_lo;
  logic [7:0]    d_data;
  logic          d_error;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_data;
  logic          resp_valid;
  logic [7:0]    resp_data;
  logic          resp_error;

  always #5 clock = ~clock;

  ux607_tl_qspi_byte_responder #(.ADDR_W(AW), .SRC_W(SW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .io_in_a_ready(a_ready), .io_in_a_valid(a_valid),
    .io_in_a_bits_opcode(a_opcode), .io_in_a_bits_param(a_param),
    .io_in_a_bits_size(a_size), .io_in_a_bits_source(a_source),
    .io_in_a_bits_address(a_address), .io_in_a_bits_mask(a_mask),
    .io_in_a_bits_data(a_data),
    .io_in_d_ready(d_ready), .io_in_d_valid(d_valid),
    .io_in_d_bits_opcode(d_opcode), .io_in_d_bits_param(d_param),
    .io_in_d_bits_size(d_size), .io_in_d_bits_source(d_source),
    .io_in_d_bits_sink(d_sink), .io_in_d_bits_addr_lo(d_addr_lo),
    .io_in_d_bits_data(d_data), .io_in_d_bits_error(d_error),
    .io_eng_req_valid(req_valid), .io_eng_req_ready(req_ready),
    .io_eng_req_write(req_write), .io_eng_req_addr(req_addr),
    .io_eng_req_data(req_data),
    .io_eng_resp_valid(resp_valid), .io_eng_resp_data(resp_data),
    .io_eng_resp_error(resp_error)
  );

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [7:0]    d;
  } req_t;

  typedef struct {
    logic [2:0]    op;
    logic [2:0]    sz;
    logic [SW-1:0] src;
    logic          lo;
    logic [7:0]    data;
    logic          err;
  } dexp_t;

  req_t  rq[$];
  dexp_t dq[$];
  bit    busy   = 1'b0;
  bit    mon_en = 1'b0;
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;

  int         lat;
  logic [7:0] gdata;
  logic       gerr;
  logic [2:0] gop;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the expectation queues.
  always @(negedge clock) begin
    if (mon_en) begin
      chk("a_ready", a_ready, (!busy && reset));
      if (req_valid) begin
        if (rq.size() == 0) begin
          chk("req_valid_unexpected", req_valid, 0);
        end else begin
          chk("req_write", req_write, rq[0].w);
          chk("req_addr", req_addr, rq[0].a);
          chk("req_data", req_data, rq[0].d);
          if (req_ready) void'(rq.pop_front());
        end
      end
      if (d_valid) begin
        if (dq.size() == 0) begin
          chk("d_valid_unexpected", d_valid, 0);
        end else begin
          chk("d_opcode", d_opcode, dq[0].op);
          chk("d_size", d_size, dq[0].sz);
          chk("d_source", d_source, dq[0].src);
          chk("d_addr_lo", d_addr_lo, dq[0].lo);
          chk("d_data", d_data, dq[0].data);
          chk("d_error", d_error, dq[0].err);
          chk("d_param", d_param, 0);
          chk("d_sink", d_sink, 0);
          if (d_ready) void'(dq.pop_front());
        end
      end
    end
  end

  // One A beat end to end. Called just after a rising edge with the DUT idle.
  // resp_delay<0 means the engine never answers; rst_wait resets in WAIT.
  task automatic do_txn(input logic [2:0] op, input logic [2:0] sz,
                        input logic [SW-1:0] src, input logic [AW-1:0] addr,
                        input logic mask, input logic [7:0] wd,
                        input int req_delay, input int resp_delay,
                        input logic [7:0] rdata, input logic rerr,
                        input int d_delay, input bit rst_wait,
                        output int olat, output logic [7:0] odata,
                        output logic oerr, output logic [2:0] oop);
    bit    legal, eng, done;
    dexp_t e;
    req_t  r;
    int    t0, n, held;
    olat  = -1;
    odata = 8'h00;
    oerr  = 1'b0;
    oop   = 3'd7;
    legal = ((op == 3'd0) || (op == 3'd1) || (op == 3'd4)) && (sz == 3'd0);
    eng   = legal && !((op != 3'd4) && !mask);
    e.op  = (op == 3'd4) ? 3'd1 : 3'd0;
    e.sz  = sz;
    e.src = src;
    e.lo  = addr[0];
    if (!legal) begin
      e.data = 8'h00; e.err = 1'b1;
    end else if (!eng) begin
      e.data = 8'h00; e.err = 1'b0;
    end else if (resp_delay >= 0 && resp_delay < TO) begin
      e.data = (op == 3'd4) ? rdata : 8'h00; e.err = rerr;
    end else begin
      e.data = 8'h00; e.err = 1'b1;
    end
    if (eng) begin
      r.w = (op != 3'd4); r.a = addr; r.d = wd;
      rq.push_back(r);
    end
    dq.push_back(e);

    a_valid = 1'b1; a_opcode = op; a_size = sz; a_source = src;
    a_address = addr; a_mask = mask; a_data = wd; a_param = 3'd5;
    @(negedge clock);
    chk("a_ready_before_fire", a_ready, 1);
    t0 = cyc;
    @(posedge clock); #1;
    a_valid = 1'b0;
    busy = 1'b1;

    if (eng) begin
      n = 0; done = 1'b0;
      while (!done && n < 20) begin
        req_ready = (n >= req_delay);
        @(negedge clock);
        if (n == 0) chk("req_valid_cycle1", req_valid, 1);
        done = req_valid && req_ready;
        @(posedge clock); #1;
        n++;
      end
      req_ready = 1'b0;
      chk("req_accepted", done, 1);
      if (rst_wait) begin
        reset = 1'b0;
        dq.delete();
        busy = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("idle_after_reset_d_valid", d_valid, 0);
        chk("a_ready_after_reset", a_ready, 1);
        @(posedge clock); #1;
        return;
      end
      if (resp_delay >= 0) begin
        repeat (resp_delay) begin
          @(posedge clock); #1;
        end
        resp_valid = 1'b1; resp_data = rdata; resp_error = rerr;
        @(posedge clock); #1;
        resp_valid = 1'b0; resp_data = 8'h00; resp_error = 1'b0;
      end
    end

    n = 0; done = 1'b0; held = 0;
    while (!done && n < 600) begin
      if (d_valid) begin
        if (olat < 0) begin
          olat = cyc - t0; odata = d_data; oerr = d_error; oop = d_opcode;
        end
        d_ready = (held >= d_delay);
        held++;
      end else begin
        d_ready = 1'b0;
      end
      @(negedge clock);
      done = d_valid && d_ready;
      @(posedge clock); #1;
      n++;
    end
    d_ready = 1'b0;
    busy = 1'b0;
    chk("d_fired", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_valid = 0; a_opcode = 0; a_param = 0; a_size = 0; a_source = 0;
    a_address = 0; a_mask = 0; a_data = 0; d_ready = 0; req_ready = 0;
    resp_valid = 0; resp_data = 0; resp_error = 0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    mon_en = 1'b1;
    @(negedge clock);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_d_bits", {d_opcode, d_param, d_size, d_source, d_sink, d_addr_lo, d_data, d_error}, 0);
    chk("rst_req_bits", {req_write, req_addr, req_data}, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("a_ready_after_release", a_ready, 1);
    @(posedge clock); #1;

    // Get, engine answers one cycle after acceptance.
    do_txn(3'd4, 3'd0, 7'h25, 30'h1001, 1'b1, 8'h00, 0, 0, 8'hA5, 1'b0, 0, 1'b0, lat, gdata, gerr, gop);
    chk("get_lat", lat, 3); chk("get_data", gdata, 8'hA5); chk("get_op", gop, 1); chk("get_err", gerr, 0);

    // PutFull, engine reports an error.
    do_txn(3'd0, 3'd0, 7'h41, 30'h2000, 1'b1, 8'h3C, 0, 0, 8'h77, 1'b1, 0, 1'b0, lat, gdata, gerr, gop);
    chk("put_lat", lat, 3); chk("put_data", gdata, 0); chk("put_op", gop, 0); chk("put_err", gerr, 1);

    // PutPartial with mask 0: local AccessAck.
    do_txn(3'd1, 3'd0, 7'h0A, 30'h0003, 1'b0, 8'hEE, 0, -1, 8'h00, 1'b0, 0, 1'b0, lat, gdata, gerr, gop);
    chk("mask0_lat", lat, 1); chk("mask0_err", gerr, 0); chk("mask0_op", gop, 0);

    // Arithmetic opcode: illegal.
    do_txn(3'd2, 3'd0, 7'h11, 30'h0100, 1'b1, 8'h12, 0, -1, 8'h00, 1'b0, 0, 1'b0, lat, gdata, gerr, gop);
    chk("arith_lat", lat, 1); chk("arith_err", gerr, 1); chk("arith_op", gop, 0);

    // Get with size 1: illegal, still AccessAckData opcode.
    do_txn(3'd4, 3'd1, 7'h7F, 30'h0201, 1'b1, 8'h00, 0, -1, 8'h00, 1'b0, 0, 1'b0, lat, gdata, gerr, gop);
    chk("getsz_lat", lat, 1); chk("getsz_err", gerr, 1); chk("getsz_op", gop, 1); chk("getsz_data", gdata, 0);

    // Engine never answers: timeout.
    do_txn(3'd4, 3'd0, 7'h33, 30'h3000, 1'b1, 8'h00, 0, -1, 8'h00, 1'b0, 0, 1'b0, lat, gdata, gerr, gop);
    chk("to_lat", lat, 2 + TO); chk("to_err", gerr, 1); chk("to_data", gdata, 0);

    // Late response pulse while idle must be ignored.
    resp_valid = 1'b1; resp_data = 8'hDE; resp_error = 1'b1;
    @(posedge clock); #1;
    resp_valid = 1'b0; resp_data = 8'h00; resp_error = 1'b0;
    repeat (2) begin
      @(negedge clock);
      chk("late_pulse_d_valid", d_valid, 0);
      @(posedge clock); #1;
    end

    do_txn(3'd4, 3'd0, 7'h26, 30'h1002, 1'b1, 8'h00, 0, 0, 8'h5A, 1'b0, 0, 1'b0, lat, gdata, gerr, gop);
    chk("after_late_data", gdata, 8'h5A); chk("after_late_lat", lat, 3);

    // D backpressure for 5 cycles.
    do_txn(3'd4, 3'd0, 7'h15, 30'h0ABC, 1'b1, 8'h00, 0, 0, 8'hC3, 1'b0, 5, 1'b0, lat, gdata, gerr, gop);
    chk("bp_d_lat", lat, 3); chk("bp_d_data", gdata, 8'hC3);

    // Request backpressure for 3 cycles, response 2 cycles into WAIT.
    do_txn(3'd0, 3'd0, 7'h52, 30'h1555, 1'b1, 8'h81, 3, 2, 8'hFF, 1'b0, 0, 1'b0, lat, gdata, gerr, gop);
    chk("bp_req_lat", lat, 8); chk("bp_req_data", gdata, 0); chk("bp_req_err", gerr, 0);

    // Response on the final timer cycle wins over the timeout.
    do_txn(3'd4, 3'd0, 7'h60, 30'h0007, 1'b1, 8'h00, 0, TO - 1, 8'h96, 1'b0, 0, 1'b0, lat, gdata, gerr, gop);
    chk("edge_lat", lat, 2 + TO); chk("edge_data", gdata, 8'h96); chk("edge_err", gerr, 0);

    // Reset while waiting on the engine: transaction dropped.
    do_txn(3'd4, 3'd0, 7'h44, 30'h0044, 1'b1, 8'h00, 0, -1, 8'h00, 1'b0, 0, 1'b1, lat, gdata, gerr, gop);
    repeat (3) begin
      @(negedge clock);
      chk("post_reset_no_d", d_valid, 0);
      chk("post_reset_no_req", req_valid, 0);
      @(posedge clock); #1;
    end
    do_txn(3'd4, 3'd0, 7'h45, 30'h0045, 1'b1, 8'h00, 0, 1, 8'h3E, 1'b0, 0, 1'b0, lat, gdata, gerr, gop);
    chk("post_reset_get_lat", lat, 4); chk("post_reset_get_data", gdata, 8'h3E);

    @(negedge clock);
    chk("rq_drained", rq.size(), 0);
    chk("dq_drained", dq.size(), 0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
